// File: rtl/pll_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_supervisor_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABILIZE,
      RUN,
      FAIL
   } state_e;

   localparam int unsigned LOCK_LOSS_MAX = 255;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, async active-low reset to 0.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset sequencer: pulses PLL reset, qualifies lock, retries on failure
// and releases the downstream system reset only once lock is stable.
module pll_supervisor
   import pll_supervisor_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYCLES    = 50,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES         = 3,
   parameter int unsigned CNT_W               = 16
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked_i,
   input  logic       soft_req,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       pll_ok,
   output logic       pll_fail,
   output logic [1:0] retry_cnt,
   output logic [7:0] lock_loss_cnt
);

   localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;

   if (RST_PULSE_CYCLES > CNT_RANGE || RST_PULSE_CYCLES == 0) begin : g_err_rst
      $error("RST_PULSE_CYCLES out of range for CNT_W");
   end
   if (LOCK_TIMEOUT_CYCLES > CNT_RANGE || LOCK_TIMEOUT_CYCLES == 0) begin : g_err_to
      $error("LOCK_TIMEOUT_CYCLES out of range for CNT_W");
   end
   if (LOCK_STABLE_CYCLES > CNT_RANGE || LOCK_STABLE_CYCLES == 0) begin : g_err_st
      $error("LOCK_STABLE_CYCLES out of range for CNT_W");
   end
   if (MAX_RETRIES > 3 || MAX_RETRIES == 0) begin : g_err_retry
      $error("MAX_RETRIES must be 1..3 to fit retry_cnt");
   end

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);
   localparam logic [7:0]       LOSS_SAT    = 8'(LOCK_LOSS_MAX);

   logic locked_s;

   sync_2ff u_lock_sync (
      .clk_i  (refclk),
      .rst_ni (rst_n),
      .d_i    (pll_locked_i),
      .q_o    (locked_s)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       retry_q, retry_d;
   logic [7:0]       loss_q, loss_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             pll_ok_q, pll_ok_d;
   logic             pll_fail_q, pll_fail_d;
   logic             attempt_fail;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_PLL;
         timer_q     <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         pll_ok_q    <= 1'b0;
         pll_fail_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         pll_ok_q    <= pll_ok_d;
         pll_fail_q  <= pll_fail_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      retry_d      = retry_q;
      loss_d       = loss_q;
      attempt_fail = 1'b0;

      unique case (state_q)
         RESET_PLL: begin
            if (timer_q == RST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s)                    state_d = STABILIZE;
            else if (timer_q == TIMEOUT_LAST) attempt_fail = 1'b1;
         end
         STABILIZE: begin
            if (!locked_s) begin
               attempt_fail = 1'b1;
            end else if (timer_q == STABLE_LAST) begin
               state_d = RUN;
               retry_d = '0;
            end
         end
         RUN: begin
            // Lock loss takes priority over a simultaneous soft request.
            if (!locked_s) begin
               state_d = RESET_PLL;
               if (loss_q != LOSS_SAT) loss_d = loss_q + 8'd1;
            end else if (soft_req) begin
               state_d = RESET_PLL;
            end
         end
         FAIL: begin
            if (soft_req) begin
               state_d = RESET_PLL;
               retry_d = '0;
            end
         end
         default: state_d = RESET_PLL;
      endcase

      if (attempt_fail) begin
         retry_d = retry_q + 2'd1;
         state_d = (retry_d == RETRY_LIMIT) ? FAIL : RESET_PLL;
      end

      if (state_d != state_q)
         timer_d = '0;
      else if (state_q == RESET_PLL || state_q == WAIT_LOCK || state_q == STABILIZE)
         timer_d = timer_q + CNT_W'(1);
      else
         timer_d = '0;

      // Outputs are decoded from the next state so they change on state entry.
      pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAIL);
      sys_rst_n_d = (state_d == RUN);
      pll_ok_d    = (state_d == RUN);
      pll_fail_d  = (state_d == FAIL);
   end

   assign pll_rst       = pll_rst_q;
   assign sys_rst_n     = sys_rst_n_q;
   assign pll_ok        = pll_ok_q;
   assign pll_fail      = pll_fail_q;
   assign retry_cnt     = retry_q;
   assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed self-checking bench for pll_supervisor with short cycle parameters.
module tb_pll_supervisor;

   logic       refclk = 1'b0;
   logic       rst_n;
   logic       pll_locked_i;
   logic       soft_req;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       pll_ok;
   logic       pll_fail;
   logic [1:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 refclk = ~refclk;

   pll_supervisor #(
      .RST_PULSE_CYCLES    (4),
      .LOCK_TIMEOUT_CYCLES (20),
      .LOCK_STABLE_CYCLES  (8),
      .MAX_RETRIES         (3),
      .CNT_W               (16)
   ) dut (
      .refclk        (refclk),
      .rst_n         (rst_n),
      .pll_locked_i  (pll_locked_i),
      .soft_req      (soft_req),
      .pll_rst       (pll_rst),
      .sys_rst_n     (sys_rst_n),
      .pll_ok        (pll_ok),
      .pll_fail      (pll_fail),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   // Advance n active edges, landing 1 ns after the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   // Leaves the bench 1 ns after "edge 0"; the next edge is edge 1.
   task automatic do_reset(input logic locked);
      rst_n        = 1'b0;
      soft_req     = 1'b0;
      pll_locked_i = locked;
      repeat (3) @(posedge refclk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      soft_req     = 1'b0;
      pll_locked_i = 1'b0;
      tick(2);
      n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst got %b exp 1", pll_rst); end
      n_cmp++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n got %b exp 0", sys_rst_n); end
      n_cmp++; if (pll_ok !== 1'b0) begin n_fail++; $display("FAIL reset_pll_ok got %b exp 0", pll_ok); end
      n_cmp++; if (pll_fail !== 1'b0) begin n_fail++; $display("FAIL reset_pll_fail got %b exp 0", pll_fail); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_retry got %0d exp 0", retry_cnt); end
      n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss got %0d exp 0", lock_loss_cnt); end
   endtask

   // Locked rises after edge 6 -> RUN at edge 17.
   task automatic test_clean_lock();
      do_reset(1'b0);
      for (int k = 1; k <= 17; k++) begin
         tick(1);
         n_cmp++; if (pll_rst !== (k < 4)) begin n_fail++; $display("FAIL clean_pll_rst k=%0d got %b exp %b", k, pll_rst, (k < 4)); end
         n_cmp++; if (sys_rst_n !== (k >= 17)) begin n_fail++; $display("FAIL clean_sys_rst_n k=%0d got %b exp %b", k, sys_rst_n, (k >= 17)); end
         if (k == 6) pll_locked_i = 1'b1;
      end
      n_cmp++; if (pll_ok !== 1'b1) begin n_fail++; $display("FAIL clean_pll_ok got %b exp 1", pll_ok); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL clean_retry got %0d exp 0", retry_cnt); end
   endtask

   // Three 4-cycle pulses 24 apart, FAIL at edge 72, then soft_req recovery.
   task automatic test_never_lock_and_fail_exit();
      logic       exp_rst;
      logic [1:0] exp_retry;
      do_reset(1'b0);
      for (int k = 1; k <= 80; k++) begin
         tick(1);
         exp_rst   = (k < 4) || (k >= 24 && k < 28) || (k >= 48 && k < 52) || (k >= 72);
         exp_retry = (k < 24) ? 2'd0 : (k < 48) ? 2'd1 : (k < 72) ? 2'd2 : 2'd3;
         n_cmp++; if (pll_rst !== exp_rst) begin n_fail++; $display("FAIL never_pll_rst k=%0d got %b exp %b", k, pll_rst, exp_rst); end
         n_cmp++; if (retry_cnt !== exp_retry) begin n_fail++; $display("FAIL never_retry k=%0d got %0d exp %0d", k, retry_cnt, exp_retry); end
         n_cmp++; if (pll_fail !== (k >= 72)) begin n_fail++; $display("FAIL never_pll_fail k=%0d got %b exp %b", k, pll_fail, (k >= 72)); end
         n_cmp++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL never_sys_rst_n k=%0d got %b exp 0", k, sys_rst_n); end
      end
      soft_req = 1'b1;
      tick(1);
      soft_req     = 1'b0;
      pll_locked_i = 1'b1;
      n_cmp++; if (pll_fail !== 1'b0) begin n_fail++; $display("FAIL failexit_pll_fail got %b exp 0", pll_fail); end
      n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL failexit_pll_rst got %b exp 1", pll_rst); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL failexit_retry got %0d exp 0", retry_cnt); end
      tick(12);
      n_cmp++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL failexit_early_release got %b exp 0", sys_rst_n); end
      tick(1);
      n_cmp++; if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL failexit_relock got %b exp 1", sys_rst_n); end
      n_cmp++; if (pll_ok !== 1'b1) begin n_fail++; $display("FAIL failexit_pll_ok got %b exp 1", pll_ok); end
   endtask

   // soft_req sampled at edge 10 in WAIT_LOCK must not disturb the timeout at 24.
   task automatic test_soft_wait();
      do_reset(1'b0);
      tick(9);
      soft_req = 1'b1;
      tick(1);
      soft_req = 1'b0;
      n_cmp++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL softwait_pll_rst got %b exp 0", pll_rst); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL softwait_retry got %0d exp 0", retry_cnt); end
      tick(13);
      n_cmp++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL softwait_retry23 got %0d exp 0", retry_cnt); end
      n_cmp++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL softwait_pll_rst23 got %b exp 0", pll_rst); end
      tick(1);
      n_cmp++; if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL softwait_timeout got %0d exp 1", retry_cnt); end
      n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL softwait_pll_rst24 got %b exp 1", pll_rst); end
   endtask

   // Locked from release; drop for 3 samples mid-STABILIZE -> retry at 10, RUN at 23.
   task automatic test_glitch();
      do_reset(1'b1);
      tick(7);
      pll_locked_i = 1'b0;
      tick(3);
      n_cmp++; if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL glitch_retry got %0d exp 1", retry_cnt); end
      n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL glitch_pll_rst got %b exp 1", pll_rst); end
      pll_locked_i = 1'b1;
      tick(12);
      n_cmp++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL glitch_early_release got %b exp 0", sys_rst_n); end
      tick(1);
      n_cmp++; if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL glitch_release got %b exp 1", sys_rst_n); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL glitch_run_retry got %0d exp 0", retry_cnt); end
      n_cmp++; if (pll_ok !== 1'b1) begin n_fail++; $display("FAIL glitch_pll_ok got %b exp 1", pll_ok); end
   endtask

   // Entered just after RUN entry edge R; soft_req re-sequences, RUN again at R+14.
   task automatic test_soft_run();
      soft_req = 1'b1;
      tick(1);
      soft_req = 1'b0;
      n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL softrun_pll_rst got %b exp 1", pll_rst); end
      n_cmp++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL softrun_sys_rst_n got %b exp 0", sys_rst_n); end
      n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL softrun_loss got %0d exp 0", lock_loss_cnt); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL softrun_retry got %0d exp 0", retry_cnt); end
      tick(13);
      n_cmp++; if (pll_ok !== 1'b1) begin n_fail++; $display("FAIL softrun_relock got %b exp 1", pll_ok); end
   endtask

   // One-cycle lock drop after RUN entry R: reset at R+3, RUN again at R+16.
   task automatic test_lock_loss();
      logic [7:0] exp_loss;
      for (int i = 1; i <= 260; i++) begin
         exp_loss     = (i > 255) ? 8'd255 : 8'(i);
         pll_locked_i = 1'b0;
         tick(1);
         pll_locked_i = 1'b1;
         tick(1);
         if (i == 2) soft_req = 1'b1;
         n_cmp++; if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL loss_early i=%0d got %b exp 1", i, sys_rst_n); end
         tick(1);
         soft_req = 1'b0;
         n_cmp++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL loss_sys_rst_n i=%0d got %b exp 0", i, sys_rst_n); end
         n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL loss_pll_rst i=%0d got %b exp 1", i, pll_rst); end
         n_cmp++; if (lock_loss_cnt !== exp_loss) begin n_fail++; $display("FAIL loss_cnt i=%0d got %0d exp %0d", i, lock_loss_cnt, exp_loss); end
         tick(13);
         n_cmp++; if (pll_ok !== 1'b1) begin n_fail++; $display("FAIL loss_relock i=%0d got %b exp 1", i, pll_ok); end
      end
   endtask

   // From RUN with saturated loss count: force a retry, then async reset mid-STABILIZE.
   task automatic test_async_reset();
      pll_locked_i = 1'b0;
      tick(1);
      pll_locked_i = 1'b1;
      tick(8);
      pll_locked_i = 1'b0;
      tick(1);
      pll_locked_i = 1'b1;
      tick(9);
      n_cmp++; if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL async_pre_retry got %0d exp 1", retry_cnt); end
      n_cmp++; if (lock_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL async_pre_loss got %0d exp 255", lock_loss_cnt); end
      n_cmp++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL async_pre_pll_rst got %b exp 0", pll_rst); end
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL async_pll_rst got %b exp 1", pll_rst); end
      n_cmp++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL async_sys_rst_n got %b exp 0", sys_rst_n); end
      n_cmp++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL async_retry got %0d exp 0", retry_cnt); end
      n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL async_loss got %0d exp 0", lock_loss_cnt); end
      @(posedge refclk);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick(1);
         n_cmp++; if (pll_rst !== (k < 4)) begin n_fail++; $display("FAIL async_rerun_pll_rst k=%0d got %b exp %b", k, pll_rst, (k < 4)); end
         n_cmp++; if (sys_rst_n !== (k >= 13)) begin n_fail++; $display("FAIL async_rerun_sys k=%0d got %b exp %b", k, sys_rst_n, (k >= 13)); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_never_lock_and_fail_exit();
      test_soft_wait();
      test_glitch();
      test_soft_run();
      test_lock_loss();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Controls the PLL from the reference-clock side: drives the PLL reset, monitors its locked flag, and qualifies lock before releasing the downstream system reset.
- Retries lock with a bounded retry count, enters a fail state when retries run out, and counts lock-loss events.
- Sits between the board oscillator and the PLL wrapper, and feeds sys_rst_n to the 50/200 MHz domains, which add their own local reset synchronizers.

Parameters:
- RST_PULSE_CYCLES, 50, refclk cycles pll_rst is held high per reset attempt (1 us at 50 MHz).
- LOCK_TIMEOUT_CYCLES, 50000, refclk cycles allowed in WAIT_LOCK before an attempt fails (1 ms).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release.
- MAX_RETRIES, 3, failed attempts allowed before FAIL.
- CNT_W, 16, shared timer width. Elaboration error if any cycle parameter exceeds 2^CNT_W.

Ports:
- refclk  in  1  free-running reference clock (50 MHz); the only clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked_i  in  1  PLL locked flag, asynchronous to refclk.
- soft_req  in  1  single-cycle request to restart the lock sequence.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst_n  out  1  active-low downstream reset; 1 only in RUN.
- pll_ok  out  1  high only in RUN.
- pll_fail  out  1  high only in FAIL.
- retry_cnt  out  2  failed attempts in the current sequence.
- lock_loss_cnt  out  8  RUN-state lock losses, saturating at 255.

Behaviour:
- Reset (rst_n=0, async): state=RESET_PLL, timer=0, pll_rst=1, sys_rst_n=0, pll_ok=0, pll_fail=0, retry_cnt=0, lock_loss_cnt=0.
- pll_locked_i passes through a 2-flop synchronizer to give locked_s (2-cycle latency).
- All outputs are registered. Each output takes its new-state value in the first cycle of that state. The timer clears on every state entry.
- RESET_PLL: pll_rst=1. After RST_PULSE_CYCLES cycles in this state -> WAIT_LOCK.
- WAIT_LOCK: pll_rst=0.
  - locked_s=1 -> STABILIZE.
  - timer reaches LOCK_TIMEOUT_CYCLES-1 with locked_s=0 -> attempt fails.
- STABILIZE:
  - When LOCK_STABLE_CYCLES consecutive cycles with locked_s=1 have completed -> RUN.
  - locked_s=0 at any point -> attempt fails.
- Attempt fails: retry_cnt+1. If the new value equals MAX_RETRIES -> FAIL, otherwise -> RESET_PLL.
- RUN: sys_rst_n=1, pll_ok=1, retry_cnt cleared on entry.
  - locked_s=0 -> lock_loss_cnt+1 (saturating), then RESET_PLL.
  - soft_req=1 -> RESET_PLL with no count change.
  - Both in the same cycle: treated as lock loss (counter increments).
- FAIL: pll_rst=1, sys_rst_n=0, pll_fail=1. Exit only on soft_req -> RESET_PLL with retry_cnt=0.
- soft_req is ignored in RESET_PLL, WAIT_LOCK and STABILIZE.
- Lock-loss latency: pll_locked_i falls at edge t -> sys_rst_n=0 and pll_rst=1 at edge t+3.
- Release latency: pll_locked_i rises at t (in WAIT_LOCK) -> sys_rst_n=1 at t+3+LOCK_STABLE_CYCLES.
- A locked glitch shorter than 2 refclk cycles may be filtered by the synchronizer. Sync-stage metastability resolution is not specified.

Decomposition:
- Package pll_supervisor_pkg holds:
  - state enum: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL;
  - LOCK_LOSS_MAX=255 constant.
- Sub-module sync_2ff: generic 1-bit two-flop synchronizer with async active-low reset to 0; reused elsewhere.
- FSM, timer and counters live in pll_supervisor.

Test Plan (RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3):
- Clean lock: release rst_n, raise pll_locked_i 6 cycles later and hold -> pll_rst high for 4 cycles; sys_rst_n=1 and pll_ok=1 exactly 11 cycles after the locked rise; retry_cnt=0.
- Never lock: pll_locked_i=0 -> three pll_rst pulses of 4 cycles each, spaced 24 cycles apart; retry_cnt goes 1,2,3; pll_fail=1; pll_rst stays 1; sys_rst_n stays 0.
- Stabilize glitch: locked for 5 cycles, low for 3 cycles, then stable -> one retry (retry_cnt=1), then RUN; retry_cnt=0 in RUN.
- Lock loss in RUN: drop pll_locked_i at edge t -> sys_rst_n=0 and pll_rst=1 at t+3; lock_loss_cnt=1. Same cycle with soft_req -> lock_loss_cnt still increments. Repeat 260 times -> saturates at 255.
- soft_req: in FAIL -> RESET_PLL with retry_cnt=0 and the sequence relocks. In WAIT_LOCK -> ignored, timer unaffected. In RUN -> re-sequence with lock_loss_cnt unchanged.
- Async reset mid-STABILIZE: assert rst_n between edges -> pll_rst=1 and sys_rst_n=0 immediately, both counters 0; after release, a full sequence reruns.
